mux_nx1_pipe: RTL and testbench
===============================

# mux_nx1_pipe

Parametrised, pipelined N:1 multiplexer for WIDTH-bit data, built as a tree of registered 4:1 stages. It supersedes the fixed-width combinational 9:1 selector and adds valid tagging, out-of-range detection and an automatic round-robin scan mode. It sits between a bank of parallel sample sources and a single downstream consumer; it has no backpressure.

## Interface

- WIDTH, 8: data bits per channel.
- NUM_IN, 9: number of input channels (2..256).
- LEVELS, derived localparam, ceil(log4(NUM_IN)): 4:1 tree depth (2 for NUM_IN=9).
- SEL_W, derived localparam, 2*LEVELS: select width.

- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  NUM_IN*WIDTH  channel k at bits [k*WIDTH +: WIDTH].
- in_valid  in  1  sample this cycle's selection.
- sel  in  SEL_W  channel select; ignored when scan_en=1.
- scan_en  in  1  1 = internal round-robin select, 0 = external sel.
- out_data  out  WIDTH  selected data (registered).
- out_valid  out  1  out_data/out_sel/sel_err qualify this cycle.
- out_sel  out  SEL_W  channel index that produced out_data.
- sel_err  out  1  effective select was >= NUM_IN.

## Operation

- Effective select esel = scan_en ? scan_cnt : sel.
- Tree: level 0 groups inputs in fours; groups are zero-padded to 4^LEVELS inputs. Level j selects with esel[2j+1:2j]; each level's output is registered.
- Higher esel bits, esel itself, in_valid and the range flag are carried alongside the data through the stage registers, so each level uses select bits captured with the same sample.
- Out of range (esel >= NUM_IN): out_data = 0, sel_err = 1, out_sel = esel, out_valid follows in_valid. No other side effect.
- in_valid = 0: the bubble propagates, and out_valid = 0 LEVELS cycles later. Data registers may update; they are don't-care while out_valid = 0, and sel_err is forced to 0.
- Scan counter scan_cnt (SEL_W bits):
  - Held at 0 while scan_en = 0.
  - While scan_en = 1 and in_valid = 1, it advances by 1 per cycle and wraps from NUM_IN-1 to 0.
  - It never produces an out-of-range value.
- Switching scan_en: the switch takes effect on the same cycle. Clearing scan_en resets the counter to 0, so the next scan starts at channel 0.
- Reset values: out_data 0, out_valid 0, out_sel 0, sel_err 0, scan_cnt 0, and all stage registers 0.
- Reset mid-stream: all in-flight samples are discarded with no output. The first valid output after reset arrives LEVELS cycles after the first in_valid cycle following rst deassertion.

## Timing

- Latency: exactly LEVELS cycles, measured from the in_valid/sel sampling edge to out_valid high. For NUM_IN=9 this is 2 cycles.
- Throughput: one sample per cycle with no gaps required. Back-to-back selects emerge in order, one per cycle.
- No combinational path from any input to any output.
- rst asserts asynchronously: outputs go to reset values without waiting for a clock edge. Deassertion is assumed synchronised upstream.

## Structure

- Shared package mux_pkg:
  - function clog4(n) for deriving LEVELS.
  - Localparam helpers for the padded input count 4^LEVELS.
- Sub-module mux4_stage, parametrised by WIDTH:
  - One registered 4:1 lane with an async-reset output register.
  - Instantiated 4^(LEVELS-1-j) times at level j via generate.
- Top level holds the scan counter, the range check and the select/valid/tag sideband pipeline.

## Test plan

Common configuration: NUM_IN=9, WIDTH=8, LEVELS=2, channel k data = 0x10+k.

- Single select: sel=8, in_valid=1 for one cycle (edge 0) -> at edge 2, out_valid=1, out_data=0x18, out_sel=8, sel_err=0; out_valid=0 on the surrounding cycles.
- Back-to-back select: sel=0..8 on consecutive cycles with in_valid=1 -> out_data 0x10..0x18 on 9 consecutive cycles starting 2 cycles later, with no gaps.
- Out of range: sel=12 with in_valid=1 -> 2 cycles later out_valid=1, out_data=0x00, sel_err=1, out_sel=12. Next with sel=3 -> out_data=0x13, sel_err=0.
- Scan with wrap: scan_en=1, in_valid=1 for 11 cycles, sel driven to 15 -> out_sel sequence 0..8,0,1, and out_data matches each channel.
- Scan with stall: in the scan run, drop in_valid for 2 cycles mid-run -> out_valid low for exactly those 2 cycles, and the scan resumes at the next channel with no skip.
- Reset mid-stream: assert rst between clock edges while 2 samples are in flight -> all outputs go to 0 immediately. After release, sel=5 -> out_data=0x15 2 cycles later, with no stale output.

Source files
------------

// File: rtl/mux_pkg.sv
// mux_pkg: shared sizing helpers for the pipelined N:1 mux tree
package mux_pkg;

    function automatic int clog4(input int n);
        int l;
        int c;
        l = 0;
        c = 1;
        while (c < n) begin
            c = c * 4;
            l = l + 1;
        end
        return l;
    endfunction

    function automatic int pad4(input int levels);
        return 4 ** levels;
    endfunction

endpackage

// File: rtl/mux4_stage.sv
// mux4_stage: one registered 4:1 lane of the mux tree
module mux4_stage
    import mux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4*WIDTH-1:0] d,
    input  logic [1:0]         s,
    output logic [WIDTH-1:0]   q
);

    // pick one of the four lanes and register it
    always_ff @(posedge clk or posedge rst)
        if (rst) q <= '0;
        else     q <= d[s*WIDTH +: WIDTH];

endmodule

// File: rtl/mux_nx1_pipe.sv
// mux_nx1_pipe: pipelined N:1 mux tree with valid/select tagging and round-robin scan
module mux_nx1_pipe
    import mux_pkg::*;
#(
    parameter  int WIDTH  = 8,
    parameter  int NUM_IN = 9,
    localparam int LEVELS = clog4(NUM_IN),
    localparam int SEL_W  = 2 * LEVELS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic                    in_valid,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    scan_en,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    sel_err
);

    localparam int PAD = pad4(LEVELS);

    logic [SEL_W-1:0]     scan_cnt;
    logic [SEL_W-1:0]     esel;
    logic                 oor;
    logic [PAD*WIDTH-1:0] in_pad;
    logic [SEL_W-1:0]     sb_sel [LEVELS];
    logic                 sb_vld [LEVELS];
    logic                 sb_err [LEVELS];

    assign esel   = scan_en ? scan_cnt : sel;
    assign oor    = 32'(esel) >= NUM_IN;
    // unused padded channels read as zero, so out-of-range selects yield 0 data for free
    assign in_pad = (PAD*WIDTH)'(in_data);

    // round-robin channel counter: cleared while scan is off, advances only on valid samples
    always_ff @(posedge clk or posedge rst)
        if (rst)           scan_cnt <= '0;
        else if (!scan_en) scan_cnt <= '0;
        else if (in_valid) scan_cnt <= (scan_cnt == SEL_W'(NUM_IN - 1)) ? '0 : scan_cnt + 1'b1;

    // sideband travels with the data so each level sees the select of its own sample
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            for (int i = 0; i < LEVELS; i++) begin
                sb_sel[i] <= '0;
                sb_vld[i] <= 1'b0;
                sb_err[i] <= 1'b0;
            end
        end else begin
            sb_sel[0] <= esel;
            sb_vld[0] <= in_valid;
            sb_err[0] <= in_valid & oor;
            for (int i = 1; i < LEVELS; i++) begin
                sb_sel[i] <= sb_sel[i-1];
                sb_vld[i] <= sb_vld[i-1];
                sb_err[i] <= sb_err[i-1];
            end
        end

    for (genvar j = 0; j < LEVELS; j++) begin : g_lvl
        localparam int N_OUT = 4 ** (LEVELS - 1 - j);
        logic [4*N_OUT*WIDTH-1:0] d;
        logic [N_OUT*WIDTH-1:0]   q;
        logic [1:0]               s;
        if (j == 0) begin : g_first
            assign d = in_pad;
            assign s = esel[1:0];
        end else begin : g_next
            assign d = g_lvl[j-1].q;
            assign s = sb_sel[j-1][2*j+1:2*j];
        end
        for (genvar k = 0; k < N_OUT; k++) begin : g_mux
            mux4_stage #(.WIDTH(WIDTH)) u_mux (
                .clk (clk),
                .rst (rst),
                .d   (d[k*4*WIDTH +: 4*WIDTH]),
                .s   (s),
                .q   (q[k*WIDTH +: WIDTH])
            );
        end
    end

    assign out_data  = g_lvl[LEVELS-1].q;
    assign out_valid = sb_vld[LEVELS-1];
    assign out_sel   = sb_sel[LEVELS-1];
    assign sel_err   = sb_err[LEVELS-1];

endmodule

// File: tb/tb_mux_nx1_pipe.sv
// tb_mux_nx1_pipe: directed checks of the 9:1 pipelined mux (latency 2)
module tb_mux_nx1_pipe;

    logic        clk;
    logic        rst;
    logic [71:0] in_data;
    logic        in_valid;
    logic [3:0]  sel;
    logic        scan_en;
    logic [7:0]  out_data;
    logic        out_valid;
    logic [3:0]  out_sel;
    logic        sel_err;

    int checks = 0;
    int errors = 0;

    mux_nx1_pipe #(.WIDTH(8), .NUM_IN(9)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .sel       (sel),
        .scan_en   (scan_en),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_sel   (out_sel),
        .sel_err   (sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic [3:0] s, input logic sc);
        in_valid = v;
        sel      = s;
        scan_en  = sc;
        @(posedge clk);
        #1;
    endtask

    task automatic exp_out(input string tag, input logic ev, input logic [7:0] ed,
                           input logic [3:0] es, input logic ee);
        chk({tag, "_valid"}, 32'(out_valid), 32'(ev));
        chk({tag, "_err"}, 32'(sel_err), 32'(ee));
        if (ev) begin
            chk({tag, "_data"}, 32'(out_data), 32'(ed));
            chk({tag, "_sel"}, 32'(out_sel), 32'(es));
        end
    endtask

    initial begin
        int k;
        logic [7:0] vs;
        rst      = 1'b1;
        in_valid = 1'b0;
        sel      = '0;
        scan_en  = 1'b0;
        for (int i = 0; i < 9; i++) in_data[i*8 +: 8] = 8'(8'h10 + i);
        @(posedge clk);
        @(posedge clk);
        #1;
        exp_out("reset", 1'b0, 8'h00, 4'd0, 1'b0);
        chk("reset_data", 32'(out_data), 32'h0);
        chk("reset_sel", 32'(out_sel), 32'h0);
        rst = 1'b0;
        cyc(0, 0, 0);
        exp_out("idle", 0, 0, 0, 0);
        // single select of the last channel
        cyc(1, 8, 0);
        exp_out("single_pre", 0, 0, 0, 0);
        cyc(0, 0, 0);
        exp_out("single", 1, 8'h18, 8, 0);
        cyc(0, 0, 0);
        exp_out("single_post", 0, 0, 0, 0);
        // back-to-back selects 0..8
        for (int i = 0; i < 9; i++) begin
            cyc(1, 4'(i), 0);
            if (i > 0) exp_out("b2b", 1, 8'(8'h10 + i - 1), 4'(i - 1), 0);
        end
        cyc(0, 0, 0);
        exp_out("b2b_last", 1, 8'h18, 8, 0);
        cyc(0, 0, 0);
        exp_out("b2b_end", 0, 0, 0, 0);
        // out of range followed by a legal select
        cyc(1, 12, 0);
        cyc(1, 3, 0);
        exp_out("oor", 1, 8'h00, 12, 1);
        cyc(0, 0, 0);
        exp_out("oor_next", 1, 8'h13, 3, 0);
        cyc(0, 0, 0);
        exp_out("oor_end", 0, 0, 0, 0);
        // scan wrap: sel driven to 15 must be ignored
        for (int i = 0; i < 11; i++) begin
            cyc(1, 15, 1);
            if (i > 0) exp_out("scan", 1, 8'(8'h10 + (i - 1) % 9), 4'((i - 1) % 9), 0);
        end
        cyc(0, 0, 0);
        exp_out("scan_last", 1, 8'h11, 1, 0);
        cyc(0, 0, 0);
        exp_out("scan_end", 0, 0, 0, 0);
        // scan with a 2-cycle stall: channels 0,1,2,-,-,3,4,5
        vs = 8'b1110_0111;
        k  = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(vs[i], 15, 1);
            if (i > 0) begin
                if (vs[i-1]) begin
                    exp_out("stall", 1, 8'(8'h10 + k), 4'(k), 0);
                    k++;
                end else exp_out("stall_gap", 0, 0, 0, 0);
            end
        end
        cyc(0, 0, 0);
        exp_out("stall_last", 1, 8'h15, 5, 0);
        cyc(0, 0, 0);
        exp_out("stall_end", 0, 0, 0, 0);
        // asynchronous reset with two samples in flight
        cyc(1, 1, 0);
        cyc(1, 2, 0);
        in_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        exp_out("rst_async", 0, 0, 0, 0);
        chk("rst_async_data", 32'(out_data), 32'h0);
        chk("rst_async_sel", 32'(out_sel), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        cyc(0, 0, 0);
        exp_out("rst_stale", 0, 0, 0, 0);
        cyc(1, 5, 0);
        exp_out("rst_stale2", 0, 0, 0, 0);
        cyc(0, 0, 0);
        exp_out("rst_first", 1, 8'h15, 5, 0);
        cyc(0, 0, 0);
        exp_out("rst_end", 0, 0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
